mcs4_bus_tracer: RTL and testbench

- Passive bus monitor sitting directly downstream of the i4004/i4001/i4002 shared data bus.
- Taps sync, d_bus (OR of all dbus_out), cm_rom and cm_ram.
- Decodes each 8-subcycle instruction cycle (A1 A2 A3 M1 M2 X1 X2 X3) into one 32-bit trace record.
- Buffers records in a FIFO drained by the PYNQ host side over a valid/ready stream. Never drives the MCS-4 bus.

---
 rtl/mcs4_bus_tracer_pkg.sv | 23 ++
 rtl/mcs4_bus_tracer_fifo.sv | 53 +++++
 rtl/mcs4_bus_tracer.sv | 160 ++++++++++++++++
 tb/tb_mcs4_bus_tracer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mcs4_bus_tracer_pkg.sv
// Shared MCS-4 bus types: data nibble, subcycle phase and the 32-bit trace record.
package mcs4;

    localparam int TRACE_REC_W = 32;
    localparam int SYNC_ERR_W  = 8;

    typedef logic [3:0] char_t;

    typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} phase_t;

    typedef struct packed {
        logic        lost;
        logic        io_cyc;
        logic        cm_rom_m2;
        logic        rsvd;
        char_t       x3;
        char_t       x2;
        char_t       opa;
        char_t       opr;
        logic [11:0] addr;
    } trace_rec_t;

endpackage

// File: rtl/mcs4_bus_tracer_fifo.sv
// Register-file FIFO; a pushed word is visible the clock after the push, never in the same clock.
module mcs4_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             pop,
    output logic             empty,
    output logic [WIDTH-1:0] rd_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same clock frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mcs4_bus_tracer.sv
// Passive MCS-4 bus monitor: aligns to sync, assembles one record per instruction cycle, queues it.
module mcs4_bus_tracer
    import mcs4::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DROP_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  sync,
    input  char_t                 d_bus,
    input  logic                  cm_rom,
    input  char_t                 cm_ram,
    output trace_rec_t            rec_data,
    output logic                  rec_valid,
    input  logic                  rec_ready,
    output logic                  locked,
    output logic [SYNC_ERR_W-1:0] sync_errs,
    output logic [DROP_W-1:0]     dropped
);
    typedef enum logic {UNLOCKED, LOCKED} track_t;

    track_t      state, state_nxt;
    phase_t      phase, phase_nxt;
    logic        capture, commit, sync_err, discard;
    logic [11:0] addr;
    char_t       opr, opa, x2;
    logic        cm_rom_m2, io_cyc, lost;
    trace_rec_t  rec_in;
    logic        fifo_full, fifo_empty, pop, want, push, drop;

    function automatic logic [SYNC_ERR_W-1:0] sat_inc_err(input logic [SYNC_ERR_W-1:0] v);
        return (v == '1) ? v : v + SYNC_ERR_W'(1);
    endfunction

    function automatic logic [DROP_W-1:0] sat_inc_drop(input logic [DROP_W-1:0] v);
        return (v == '1) ? v : v + DROP_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= UNLOCKED;
            phase <= X3;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        capture   = 1'b0;
        commit    = 1'b0;
        sync_err  = 1'b0;
        discard   = 1'b0;
        case (state)
            UNLOCKED: begin
                if (sync) begin
                    state_nxt = LOCKED;
                    phase_nxt = A1;
                end
            end
            LOCKED: begin
                if (sync) begin
                    phase_nxt = A1;
                    if (phase == X3) begin
                        commit = 1'b1;
                    end else begin
                        sync_err = 1'b1;
                        discard  = 1'b1;
                    end
                end else if (phase == X3) begin
                    state_nxt = UNLOCKED;
                    discard   = 1'b1;
                end else begin
                    phase_nxt = phase_t'(phase + 3'd1);
                    capture   = 1'b1;
                end
            end
            default: state_nxt = UNLOCKED;
        endcase
    end

    // X3 is not registered: the committing clock takes it straight off the bus.
    always_ff @(posedge clk) begin
        if (!rst || discard) begin
            addr      <= '0;
            opr       <= '0;
            opa       <= '0;
            x2        <= '0;
            cm_rom_m2 <= 1'b0;
            io_cyc    <= 1'b0;
        end else if (capture) begin
            case (phase)
                A1: addr[3:0]  <= d_bus;
                A2: addr[7:4]  <= d_bus;
                A3: addr[11:8] <= d_bus;
                M1: opr        <= d_bus;
                M2: begin
                    opa       <= d_bus;
                    cm_rom_m2 <= cm_rom;
                end
                X2: begin
                    x2     <= d_bus;
                    io_cyc <= |cm_ram;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rec_in           = '0;
        rec_in.lost      = lost;
        rec_in.io_cyc    = io_cyc;
        rec_in.cm_rom_m2 = cm_rom_m2;
        rec_in.x3        = d_bus;
        rec_in.x2        = x2;
        rec_in.opa       = opa;
        rec_in.opr       = opr;
        rec_in.addr      = addr;
    end

    assign rec_valid = !fifo_empty;
    assign locked    = (state == LOCKED);
    assign pop       = rec_valid && rec_ready;
    assign want      = commit && enable;
    assign push      = want && (!fifo_full || pop);
    assign drop      = want && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (!rst) begin
            lost      <= 1'b0;
            sync_errs <= '0;
            dropped   <= '0;
        end else begin
            if (drop)          lost <= 1'b1;
            else if (push)     lost <= 1'b0;
            if (sync_err)      sync_errs <= sat_inc_err(sync_errs);
            if (drop)          dropped   <= sat_inc_drop(dropped);
        end
    end

    mcs4_sync_fifo #(
        .WIDTH (TRACE_REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (rec_in),
        .full    (fifo_full),
        .pop     (pop),
        .empty   (fifo_empty),
        .rd_data (rec_data)
    );

endmodule

// File: tb/tb_mcs4_bus_tracer.sv
// Directed bench for mcs4_bus_tracer: table of full instruction cycles plus hand-written corner sequences.
module tb_mcs4_bus_tracer;
    import mcs4::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b1;
    logic        sync = 1'b0;
    logic [3:0]  d_bus = 4'h0;
    logic        cm_rom = 1'b0;
    logic [3:0]  cm_ram = 4'h0;
    logic        rec_ready = 1'b0;
    logic [31:0] rec_data;
    logic        rec_valid;
    logic        locked;
    logic [7:0]  sync_errs;
    logic [7:0]  dropped;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] nib;
        logic        rom;
        logic [3:0]  ram;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    mcs4_bus_tracer #(
        .FIFO_DEPTH (16),
        .DROP_W     (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .sync      (sync),
        .d_bus     (d_bus),
        .cm_rom    (cm_rom),
        .cm_ram    (cm_ram),
        .rec_data  (rec_data),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .locked    (locked),
        .sync_errs (sync_errs),
        .dropped   (dropped)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic sub(input logic s, input logic [3:0] d, input logic rom, input logic [3:0] ram);
        sync   = s;
        d_bus  = d;
        cm_rom = rom;
        cm_ram = ram;
        @(posedge clk);
        #1;
    endtask

    // One A1..X3 cycle; nib[3:0] is the A1 nibble, nib[31:28] the X3 nibble.
    task automatic cycle(input logic [31:0] nib, input logic rom, input logic [3:0] ram,
                         input logic s_end, input logic rdy);
        rec_ready = rdy;
        for (int i = 0; i < 8; i++) begin
            sub((i == 7) ? s_end : 1'b0, nib[4*i +: 4], (i == 4) ? rom : 1'b0,
                (i == 6) ? ram : 4'h0);
        end
    endtask

    initial begin
        vecs[0] = '{32'h000D4123, 1'b0, 4'b0000, 32'h000D4123};
        vecs[1] = '{32'h5A7B6F0E, 1'b1, 4'b0001, 32'h65AB6F0E};
        vecs[2] = '{32'h12345678, 1'b0, 4'b1000, 32'h41245678};
        vecs[3] = '{32'hFFFFFFFF, 1'b1, 4'b0000, 32'h2FFFFFFF};

        rst = 1'b0;
        sub(1'b0, 4'h0, 1'b0, 4'h0);
        sub(1'b0, 4'h0, 1'b0, 4'h0);
        chk("reset_valid", 32'(rec_valid), 32'd0);
        chk("reset_data", rec_data, 32'd0);
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_sync_errs", 32'(sync_errs), 32'd0);
        chk("reset_dropped", 32'(dropped), 32'd0);
        rst = 1'b1;

        sub(1'b1, 4'h0, 1'b0, 4'h0);
        chk("first_lock", 32'(locked), 32'd1);
        chk("empty_after_lock", 32'(rec_valid), 32'd0);

        foreach (vecs[k]) begin
            cycle(vecs[k].nib, vecs[k].rom, vecs[k].ram, 1'b1, 1'b1);
            chk($sformatf("vec%0d_valid", k), 32'(rec_valid), 32'd1);
            chk($sformatf("vec%0d_data", k), rec_data, vecs[k].exp);
        end
        chk("vec_locked", 32'(locked), 32'd1);

        // Stray sync at M1.
        rec_ready = 1'b1;
        sub(1'b0, 4'h1, 1'b0, 4'h0);
        sub(1'b0, 4'h2, 1'b0, 4'h0);
        sub(1'b0, 4'h3, 1'b0, 4'h0);
        sub(1'b1, 4'h4, 1'b0, 4'h0);
        chk("syncerr_count", 32'(sync_errs), 32'd1);
        chk("syncerr_no_push", 32'(rec_valid), 32'd0);
        chk("syncerr_locked", 32'(locked), 32'd1);
        cycle(32'h00000777, 1'b0, 4'h0, 1'b1, 1'b1);
        chk("syncerr_recover", rec_data, 32'h00000777);
        chk("syncerr_count_hold", 32'(sync_errs), 32'd1);

        // Missing sync at X3.
        cycle(32'h00000111, 1'b0, 4'h0, 1'b0, 1'b1);
        chk("nosync_unlocked", 32'(locked), 32'd0);
        chk("nosync_no_push", 32'(rec_valid), 32'd0);
        cycle(32'h00000999, 1'b0, 4'h0, 1'b0, 1'b1);
        chk("idle_unlocked", 32'(locked), 32'd0);
        chk("idle_no_push", 32'(rec_valid), 32'd0);
        sub(1'b1, 4'h0, 1'b0, 4'h0);
        chk("relock", 32'(locked), 32'd1);
        cycle(32'h00000222, 1'b0, 4'h0, 1'b1, 1'b1);
        chk("relock_data", rec_data, 32'h00000222);

        // enable only matters at the X3 commit.
        enable = 1'b0;
        cycle(32'h00000333, 1'b0, 4'h0, 1'b1, 1'b1);
        chk("disabled_no_push", 32'(rec_valid), 32'd0);
        chk("disabled_no_drop", 32'(dropped), 32'd0);
        for (int i = 0; i < 7; i++) sub(1'b0, (i == 0) ? 4'h4 : (i == 1) ? 4'h4 : 4'h0, 1'b0, 4'h0);
        enable = 1'b1;
        sub(1'b1, 4'h0, 1'b0, 4'h0);
        chk("enable_at_x3_data", rec_data, 32'h00000044);
        for (int i = 0; i < 7; i++) sub(1'b0, 4'h6, 1'b0, 4'h0);
        enable = 1'b0;
        sub(1'b1, 4'h6, 1'b0, 4'h0);
        chk("disable_at_x3_no_push", 32'(rec_valid), 32'd0);
        enable = 1'b1;

        // Overflow: 17 cycles into a 16-deep FIFO with the consumer stalled.
        for (int i = 0; i < 17; i++) begin
            cycle(32'h00000500 + 32'(i), 1'b0, 4'h0, 1'b1, (i == 0));
        end
        chk("full_dropped", 32'(dropped), 32'd1);
        chk("full_valid", 32'(rec_valid), 32'd1);
        chk("full_head_held", rec_data, 32'h00000500);
        rec_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d", i), rec_data, 32'h00000500 + 32'(i));
            sub(1'b0, 4'h0, 1'b0, 4'h0);
        end
        chk("drained_empty", 32'(rec_valid), 32'd0);
        chk("drained_dropped", 32'(dropped), 32'd1);
        sub(1'b1, 4'h0, 1'b0, 4'h0);
        cycle(32'h00000ABC, 1'b0, 4'h0, 1'b1, 1'b1);
        chk("lost_flag_set", rec_data, 32'h80000ABC);
        cycle(32'h00000DEF, 1'b0, 4'h0, 1'b1, 1'b1);
        chk("lost_flag_clear", rec_data, 32'h00000DEF);

        // Reset at M2 with three records queued.
        cycle(32'h00000601, 1'b0, 4'h0, 1'b1, 1'b1);
        cycle(32'h00000602, 1'b0, 4'h0, 1'b1, 1'b0);
        cycle(32'h00000603, 1'b0, 4'h0, 1'b1, 1'b0);
        chk("queued_head", rec_data, 32'h00000601);
        sub(1'b0, 4'h1, 1'b0, 4'h0);
        sub(1'b0, 4'h2, 1'b0, 4'h0);
        sub(1'b0, 4'h3, 1'b0, 4'h0);
        sub(1'b0, 4'h4, 1'b0, 4'h0);
        rst = 1'b0;
        sub(1'b0, 4'h5, 1'b0, 4'h0);
        chk("midrst_valid", 32'(rec_valid), 32'd0);
        chk("midrst_data", rec_data, 32'd0);
        chk("midrst_dropped", 32'(dropped), 32'd0);
        chk("midrst_locked", 32'(locked), 32'd0);
        chk("midrst_sync_errs", 32'(sync_errs), 32'd0);
        rst = 1'b1;
        sub(1'b1, 4'h0, 1'b0, 4'h0);
        cycle(32'h00000ACE, 1'b0, 4'h0, 1'b1, 1'b1);
        chk("postrst_data", rec_data, 32'h00000ACE);
        sub(1'b0, 4'h0, 1'b0, 4'h0);
        chk("postrst_no_stale", 32'(rec_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
